// File: rtl/sequencer_pkg.sv
// -----------------------------------------------------------------------------
// sequencer_pkg
// Shared types and default parameters for the operand sequencer slice.
//   state_t          : control FSM states
//   OP_W_DEF         : default opcode width
//   EXEC_CYCLES_DEF  : default ALU latency in cycles
// -----------------------------------------------------------------------------
package sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    EXEC   = 3'd2,
    WRITE  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  localparam int OP_W_DEF        = 3;
  localparam int EXEC_CYCLES_DEF = 2;

endpackage

// File: rtl/cycle_counter.sv
// -----------------------------------------------------------------------------
// cycle_counter
// Loadable down-counter that stops at zero.
//   clk, reset  : system clock, asynchronous active-high reset
//   load        : load load_value (has priority over en)
//   en          : decrement by one while non-zero
//   load_value  : value to load
//   zero        : count is zero
// -----------------------------------------------------------------------------
module cycle_counter #(
  parameter int MAX_COUNT = 2,
  localparam int W        = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
// Control FSM for a two-operand compute datapath: captures operand A (with
// its opcode) and operand B on successive inputdata_ready pulses, runs the
// ALU for EXEC_CYCLES cycles, commits the result and holds result_valid
// until the consumer acknowledges.
//   clk, reset       : system clock, asynchronous active-high reset
//   inputdata_ready  : one-cycle pulse, operand valid on the input bus
//   opcode_in        : opcode, sampled with operand A
//   abort            : synchronous cancel of the current transaction
//   result_ack       : consumer accepts the result
//   load_a, load_b   : operand register enables (same-cycle as the pulse)
//   alu_op           : registered opcode for the ALU
//   exec_en          : ALU enable
//   result_load      : result register enable
//   result_valid     : result available to the consumer
//   busy             : transaction in progress
//   overrun          : sticky, an operand pulse arrived while not accepting
// -----------------------------------------------------------------------------
module operand_sequencer
  import sequencer_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int EXEC_CYCLES = EXEC_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inputdata_ready,
  input  logic [OP_W-1:0] opcode_in,
  input  logic            abort,
  input  logic            result_ack,
  output logic            load_a,
  output logic            load_b,
  output logic [OP_W-1:0] alu_op,
  output logic            exec_en,
  output logic            result_load,
  output logic            result_valid,
  output logic            busy,
  output logic            overrun
);

  localparam int              CNT_W     = $clog2(EXEC_CYCLES + 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t state, next_state;
  logic   accept_a, accept_b, drop_pulse, cnt_zero;

  // Operand acceptance; gated by reset so no enable escapes while in reset.
  assign accept_a   = (state == IDLE)   && inputdata_ready && !abort && !reset;
  assign accept_b   = (state == WAIT_B) && inputdata_ready && !abort && !reset;
  // A pulse arriving after both operands are taken is lost; abort wins.
  assign drop_pulse = inputdata_ready && !abort &&
                      ((state == EXEC) || (state == WRITE) || (state == HOLD));

  cycle_counter #(
    .MAX_COUNT (EXEC_CYCLES)
  ) u_cycle_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept_b),
    .en         (state == EXEC),
    .load_value (EXEC_LOAD),
    .zero       (cnt_zero)
  );

  // NOTE: the async reset is in the sensitivity list, so the block returns to
  // IDLE immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      alu_op  <= '0;
      overrun <= 1'b0;
    end else begin
      state <= next_state;
      if (accept_a) alu_op <= opcode_in;
      if (drop_pulse) overrun <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept_a) next_state = WAIT_B;
      WAIT_B:  if (abort) next_state = IDLE;
               else if (inputdata_ready) next_state = EXEC;
      EXEC:    if (abort) next_state = IDLE;
               else if (cnt_zero) next_state = WRITE;
      WRITE:   next_state = abort ? IDLE : HOLD;
      HOLD:    if (abort || result_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_a       = accept_a;
    load_b       = accept_b;
    exec_en      = (state == EXEC);
    // Abort cancels the commit and the handshake in the cycle it arrives.
    result_load  = (state == WRITE) && !abort;
    result_valid = (state == HOLD)  && !abort;
    busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_operand_sequencer
// Three sequencer instances (EXEC_CYCLES = 2, 1, 15) share one stimulus
// stream. A transaction-level model tracks, per instance, whether operand A
// is held and how many cycles have passed since operand B; expected outputs
// follow from the timing rules of that age.
// -----------------------------------------------------------------------------
module tb_operand_sequencer;

  localparam int N = 3;
  localparam int E_TAB [N] = '{2, 1, 15};

  logic       clk = 1'b0;
  logic       reset, rdy, abort, ack;
  logic [2:0] op;

  logic       la [N], lb [N], ex [N], rl [N], rv [N], bz [N], ov [N];
  logic [2:0] alu [N];

  operand_sequencer #(.OP_W(3), .EXEC_CYCLES(2)) u_e2 (
    .clk(clk), .reset(reset), .inputdata_ready(rdy), .opcode_in(op),
    .abort(abort), .result_ack(ack), .load_a(la[0]), .load_b(lb[0]),
    .alu_op(alu[0]), .exec_en(ex[0]), .result_load(rl[0]),
    .result_valid(rv[0]), .busy(bz[0]), .overrun(ov[0]));

  operand_sequencer #(.OP_W(3), .EXEC_CYCLES(1)) u_e1 (
    .clk(clk), .reset(reset), .inputdata_ready(rdy), .opcode_in(op),
    .abort(abort), .result_ack(ack), .load_a(la[1]), .load_b(lb[1]),
    .alu_op(alu[1]), .exec_en(ex[1]), .result_load(rl[1]),
    .result_valid(rv[1]), .busy(bz[1]), .overrun(ov[1]));

  operand_sequencer #(.OP_W(3), .EXEC_CYCLES(15)) u_e15 (
    .clk(clk), .reset(reset), .inputdata_ready(rdy), .opcode_in(op),
    .abort(abort), .result_ack(ack), .load_a(la[2]), .load_b(lb[2]),
    .alu_op(alu[2]), .exec_en(ex[2]), .result_load(rl[2]),
    .result_valid(rv[2]), .busy(bz[2]), .overrun(ov[2]));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit measure = 1'b0;
  int last_la [N];
  int run_len [N];

  // Reference model state
  bit         m_have_a [N];
  bit         m_run    [N];
  int         m_age    [N];   // cycles since operand B was accepted
  logic [2:0] m_alu    [N];
  bit         m_ovr    [N];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_have_a[i] = 1'b0;
      m_run[i]    = 1'b0;
      m_age[i]    = 0;
      m_alu[i]    = 3'd0;
      m_ovr[i]    = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int  e;
      bit  idle;
      e    = E_TAB[i];
      idle = !m_have_a[i] && !m_run[i];
      if (idle) begin
        if (rdy && !abort) begin
          m_have_a[i] = 1'b1;
          m_alu[i]    = op;
        end
      end else if (abort) begin
        m_have_a[i] = 1'b0;
        m_run[i]    = 1'b0;
      end else if (m_have_a[i]) begin
        if (rdy) begin
          m_have_a[i] = 1'b0;
          m_run[i]    = 1'b1;
          m_age[i]    = 1;
        end
      end else begin
        if (rdy) m_ovr[i] = 1'b1;
        if ((m_age[i] >= e + 2) && ack) m_run[i] = 1'b0;
        else m_age[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int    e;
      bit    idle;
      string s;
      e    = E_TAB[i];
      idle = !m_have_a[i] && !m_run[i];
      s    = $sformatf("[E=%0d]", e);
      chk({"load_a", s}, 8'(la[i]), 8'(!reset && idle && rdy && !abort));
      chk({"load_b", s}, 8'(lb[i]), 8'(!reset && m_have_a[i] && rdy && !abort));
      chk({"exec_en", s}, 8'(ex[i]),
          8'(m_run[i] && (m_age[i] >= 1) && (m_age[i] <= e)));
      chk({"result_load", s}, 8'(rl[i]), 8'(m_run[i] && (m_age[i] == e + 1) && !abort));
      chk({"result_valid", s}, 8'(rv[i]), 8'(m_run[i] && (m_age[i] >= e + 2) && !abort));
      chk({"busy", s}, 8'(bz[i]), 8'(!idle));
      chk({"overrun", s}, 8'(ov[i]), 8'(m_ovr[i]));
      chk({"alu_op", s}, 8'(alu[i]), 8'(m_alu[i]));
    end
  endtask

  // exec_en run length and back-to-back period, used with ready and ack
  // held high so every instance cycles at its minimum period.
  task automatic do_measure();
    for (int i = 0; i < N; i++) begin
      if (la[i]) begin
        if (last_la[i] >= 0)
          chk($sformatf("period[E=%0d]", E_TAB[i]), 8'(cyc - last_la[i]), 8'(E_TAB[i] + 4));
        last_la[i] = cyc;
      end
      if (ex[i]) begin
        run_len[i]++;
      end else if (run_len[i] > 0) begin
        chk($sformatf("exec_width[E=%0d]", E_TAB[i]), 8'(run_len[i]), 8'(E_TAB[i]));
        run_len[i] = 0;
      end
    end
  endtask

  // One clock cycle: drive at edge+1, check mid-cycle, advance model at edge.
  task automatic cycle(input logic r, input logic [2:0] o, input logic ab, input logic ak);
    rdy = r; op = o; abort = ab; ack = ak;
    #3;
    check_all();
    if (measure) do_measure();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rdy = 1'b0; op = 3'd0; abort = 1'b0; ack = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; op = 3'd0; abort = 1'b0; ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Normal transaction: A at 5 with opcode 101, B at 8, ack at 14.
    for (int c = 0; c < 20; c++)
      cycle(c == 5 || c == 8, (c == 5) ? 3'b101 : 3'b010, 1'b0, c == 14);
    chk("alu_op_hold", 8'(alu[0]), 8'h5);

    // Extra pulse during EXEC sets overrun, which survives a full transaction.
    cycle(1, 3'b011, 0, 0);
    cycle(1, 3'b000, 0, 0);
    cycle(1, 3'b000, 0, 0);
    for (int c = 0; c < 20; c++) cycle(0, 3'b000, 0, c >= 2);
    cycle(1, 3'b110, 0, 0);
    cycle(1, 3'b000, 0, 0);
    for (int c = 0; c < 20; c++) cycle(0, 3'b000, 0, c >= 4);
    for (int i = 0; i < N; i++) chk($sformatf("overrun_sticky[%0d]", i), 8'(ov[i]), 8'h1);

    // Abort together with operand B; then abort while holding a result.
    apply_reset();
    cycle(1, 3'b111, 0, 0);
    cycle(1, 3'b000, 1, 0);
    cycle(0, 3'b000, 0, 0);
    cycle(1, 3'b001, 0, 0);
    cycle(1, 3'b000, 0, 0);
    for (int c = 0; c < 5; c++) cycle(0, 3'b000, 0, 0);
    cycle(0, 3'b000, 1, 0);
    cycle(0, 3'b000, 0, 0);
    cycle(1, 3'b000, 1, 0);  // abort in IDLE suppresses load_a

    // Ack plus ready in HOLD, then ready on the following cycle.
    apply_reset();
    cycle(1, 3'b100, 0, 0);
    cycle(1, 3'b000, 0, 0);
    for (int c = 0; c < 18; c++) cycle(0, 3'b000, 0, 0);
    cycle(1, 3'b000, 0, 1);
    cycle(1, 3'b010, 0, 0);
    cycle(0, 3'b000, 0, 0);

    // Asynchronous reset between edges while in EXEC.
    apply_reset();
    cycle(1, 3'b011, 0, 0);
    cycle(1, 3'b000, 0, 0);
    cycle(0, 3'b000, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Minimum-period sweep: ready and ack held high.
    for (int i = 0; i < N; i++) begin
      last_la[i] = -1;
      run_len[i] = 0;
    end
    measure = 1'b1;
    for (int c = 0; c < 60; c++) cycle(1, 3'(c), 0, 1);
    measure = 1'b0;

    // Randomized traffic.
    apply_reset();
    for (int c = 0; c < 1500; c++)
      cycle($urandom_range(0, 99) < 40, 3'($urandom),
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
